// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_fetch_pkg;

  // Fetch sequencer states: request, wait for memory, hold for decode, dead on fault.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  // Sequential instruction stride in bytes.
  localparam int PC_STEP = 4;

  // Default architectural PC after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True when an address sits on a 4-byte instruction boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential PC+4 or branch target, plus alignment check.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module pc_next_sel
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr_pc,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            branch,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic            take;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;

  // Branch is taken only when the controller asks and the ALU compared equal;
  // both adds wrap modulo 2^XLEN so PC+4 from the top of memory lands on 0.
  always_comb begin
    take       = branch & zero;
    target     = instr_pc + (branch_offset << 1);
    seq_pc     = instr_pc + XLEN'(PC_STEP);
    next_pc    = take ? target : seq_pc;
    misaligned = !is_word_aligned(next_pc);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch feeding decode.
// Latency: 2 cycles from request presented (ready=1) to instr_valid with a 1-cycle memory.
// Backpressure: imem_req_ready low holds the request; instr_ready low holds the instruction.
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] branch_offset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] retired_count
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic            req_fire;
  logic            rsp_capture;
  logic            handoff;

  // Branch resolution happens on the held instruction, so it works from instr_pc.
  pc_next_sel #(
    .XLEN (XLEN)
  ) u_next_sel (
    .instr_pc      (instr_pc),
    .branch_offset (branch_offset),
    .branch        (branch),
    .zero          (zero),
    .next_pc       (next_pc),
    .misaligned    (next_misaligned)
  );

  // The request address is always the architectural PC; it only moves on handoff.
  assign imem_addr = pc;

  // Handshake qualifiers; responses outside S_WAIT are dropped on the floor.
  assign req_fire    = (state == S_REQ)  && imem_req_valid && imem_req_ready;
  assign rsp_capture = (state == S_WAIT) && imem_rsp_valid;
  assign handoff     = (state == S_HOLD) && instr_valid && instr_ready;

  // Next-state logic for the fetch sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (req_fire)    state_nxt = S_WAIT;
      S_WAIT:  if (rsp_capture) state_nxt = S_HOLD;
      S_HOLD:  if (handoff)     state_nxt = next_misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  // State, PC, handshake flags and captured instruction; valids are registered
  // from the next state so nothing toggles combinationally off the inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_REQ;
      pc               <= RESET_PC;
      imem_req_valid   <= 1'b0;
      instr_valid      <= 1'b0;
      instr            <= '0;
      instr_pc         <= '0;
      misaligned_fault <= 1'b0;
      retired_count    <= '0;
    end else begin
      state          <= state_nxt;
      imem_req_valid <= (state_nxt == S_REQ);
      instr_valid    <= (state_nxt == S_HOLD);
      if (rsp_capture) begin
        instr    <= imem_rsp_data;
        instr_pc <= pc;
      end
      if (handoff) begin
        retired_count <= retired_count + XLEN'(1);
        if (next_misaligned) begin
          misaligned_fault <= 1'b1;
        end else begin
          pc <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: bench acts as instruction memory and decode.
// Latency: checks the 2-cycle request-to-valid path plus randomized stalls.
// Backpressure: exercises both memory-side and decode-side stalls.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] branch_offset = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned_fault;
  logic [31:0] retired_count;

  pc_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .branch           (branch),
    .zero             (zero),
    .branch_offset    (branch_offset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .misaligned_fault (misaligned_fault),
    .retired_count    (retired_count)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;

  // Reference model: architectural state as the ISA sees it.
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic        exp_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural next PC: branch target is PC + 2*offset, otherwise PC + 4.
  function automatic logic [31:0] model_next(input logic [31:0] ip, input logic take,
                                             input logic [31:0] off);
    if (take) return ip + off * 32'd2;
    return ip + 32'd4;
  endfunction

  task automatic model_reset();
    exp_pc    = RST_PC;
    exp_ret   = 32'd0;
    exp_fault = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    chk({tag, "_fault"}, 32'(misaligned_fault), 32'd0);
    chk({tag, "_retired"}, retired_count, 32'd0);
    chk({tag, "_addr"}, imem_addr, RST_PC);
  endtask

  // One full fetch/handoff transaction with optional stalls on both sides.
  task automatic fetch(input int req_stall, input int rsp_lat, input int hold_stall,
                       input logic [31:0] data, input logic br, input logic zr,
                       input logic [31:0] off);
    int          n;
    int          lat;
    logic [31:0] nxt;
    wait_req(n);
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("imem_addr", imem_addr, exp_pc);
    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = (i == 1);
      imem_rsp_data  = 32'hDEAD_0000 | 32'(i);
      @(negedge clock);
      imem_rsp_valid = 1'b0;
      chk("req_stall_valid", 32'(imem_req_valid), 32'd1);
      chk("req_stall_addr", imem_addr, exp_pc);
    end
    imem_req_ready = 1'b1;
    @(negedge clock);
    imem_req_ready = 1'b0;
    lat = 1;
    chk("req_dropped", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < rsp_lat; i++) begin
      @(negedge clock);
      lat++;
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clock);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = ~data;
    lat++;
    if (req_stall == 0 && rsp_lat == 0) chk("fetch_latency", 32'(lat), 32'd2);
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr", instr, data);
    chk("instr_pc", instr_pc, exp_pc);
    for (int i = 0; i < hold_stall; i++) begin
      instr_ready    = 1'b0;
      branch         = 1'($urandom_range(0, 1));
      zero           = 1'($urandom_range(0, 1));
      branch_offset  = $urandom;
      imem_rsp_valid = (i == 0);
      imem_rsp_data  = $urandom;
      @(negedge clock);
      imem_rsp_valid = 1'b0;
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, data);
      chk("hold_req", 32'(imem_req_valid), 32'd0);
    end
    instr_ready   = 1'b1;
    branch        = br;
    zero          = zr;
    branch_offset = off;
    @(negedge clock);
    instr_ready   = 1'b0;
    branch        = 1'($urandom_range(0, 1));
    zero          = 1'($urandom_range(0, 1));
    branch_offset = $urandom;
    exp_ret = exp_ret + 32'd1;
    nxt = model_next(exp_pc, br & zr, off);
    if ((nxt % 32'd4) != 32'd0) exp_fault = 1'b1;
    else exp_pc = nxt;
    chk("retired", retired_count, exp_ret);
    chk("fault", 32'(misaligned_fault), 32'(exp_fault));
    chk("handoff_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] off;
    model_reset();

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;

    // First fetch at RESET_PC, sequential run, then a taken branch back to 0
    fetch(0, 0, 0, 32'h0000_0013, 1'b0, 1'b0, 32'd0);
    fetch(0, 0, 0, $urandom, 1'b0, 1'b1, 32'd0);
    fetch(0, 0, 0, $urandom, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("retired_three", retired_count, 32'd3);

    // Same branch with zero clear falls through to PC+4
    fetch(0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0);
    fetch(0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0);
    fetch(0, 0, 0, $urandom, 1'b1, 1'b0, 32'hFFFF_FFFC);

    // Backpressure on both sides
    fetch(5, 1, 7, $urandom, 1'b0, 1'b0, 32'd0);

    // Randomized traffic with aligned branch offsets
    for (int k = 0; k < 30; k++) begin
      off = (32'($urandom_range(0, 40)) - 32'd20) & ~32'h1;
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), off);
    end

    // Steer to 0x10, then branch to an unaligned target
    off = 32'($signed(32'h10 - exp_pc) >>> 1);
    fetch(0, 0, 0, $urandom, 1'b1, 1'b1, off);
    chk("at_0x10", exp_pc ^ imem_addr, 32'd0);
    fetch(0, 0, 0, $urandom, 1'b1, 1'b1, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("fault_no_req", 32'(imem_req_valid), 32'd0);
      chk("fault_no_valid", 32'(instr_valid), 32'd0);
      chk("fault_sticky", 32'(misaligned_fault), 32'd1);
    end

    // Reset clears the fault and restarts at RESET_PC
    reset = 1'b1;
    #1;
    check_reset_values("fault_reset");
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Reach the top of the address space, then wrap to 0
    fetch(0, 0, 0, $urandom, 1'b1, 1'b1, 32'hFFFF_FFFE);
    fetch(0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0);
    chk("wrapped_addr", imem_addr, 32'd0);

    // Reset while waiting on memory; stray response afterwards is ignored
    wait_req(n);
    chk("inflight_addr", imem_addr, exp_pc);
    imem_req_ready = 1'b1;
    @(negedge clock);
    imem_req_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("inflight_reset");
    @(negedge clock);
    reset          = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clock);
    imem_rsp_valid = 1'b0;
    model_reset();
    chk("stray_instr_valid", 32'(instr_valid), 32'd0);
    chk("stray_instr", instr, 32'd0);
    fetch(0, 0, 0, 32'h0000_0093, 1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage; sits directly downstream of the next-PC select logic and replaces a bare PC register.
- Holds the architectural PC and computes PC+4 and the branch target internally.
- Issues one fetch at a time to instruction memory over a valid/ready request and valid response.
- Presents the fetched instruction to decode under a valid/ready handshake.
- Applies the branch decision (zero AND branch) when decode consumes the instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- branch  input  1  branch control from controller, for the instruction on instr.
- zero  input  1  ALU zero flag, for the instruction on instr.
- branch_offset  input  XLEN  sign-extended immediate, unshifted.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts request.
- imem_addr  output  XLEN  fetch address; equals pc while imem_req_valid.
- imem_rsp_valid  input  1  fetch data valid.
- imem_rsp_data  input  XLEN  fetched instruction word.
- instr_valid  output  1  instr/instr_pc valid for decode.
- instr_ready  input  1  decode consumes instr this cycle.
- instr  output  XLEN  held instruction word.
- instr_pc  output  XLEN  address of instr.
- misaligned_fault  output  1  sticky; branch target not 4-byte aligned.
- retired_count  output  XLEN  number of instructions consumed by decode.

Behaviour:
- Reset values (asynchronous):
  - pc=RESET_PC, state=S_REQ.
  - imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, misaligned_fault=0, retired_count=0.
  - All outputs are registered or decoded from state only; imem_req_valid asserts in the first cycle after reset deasserts.
- FSM states: S_REQ, S_WAIT, S_HOLD, S_FAULT.
- S_REQ:
  - imem_req_valid=1, imem_addr=pc, both stable until accepted.
  - imem_req_valid & imem_req_ready -> S_WAIT.
- S_WAIT:
  - imem_rsp_valid -> capture instr<=imem_rsp_data, instr_pc<=pc, set instr_valid=1, go to S_HOLD.
  - Response is never same-cycle as accept; minimum fetch latency is 2 cycles from request to instr_valid.
- S_HOLD:
  - instr_valid=1; instr and instr_pc held.
  - instr_ready sampled only here. On instr_valid & instr_ready:
    - retired_count += 1, wrapping modulo 2^XLEN.
    - take = branch & zero, sampled this same cycle.
    - target = instr_pc + (branch_offset << 1), modulo 2^XLEN; carry discarded.
    - next = take ? target : instr_pc + 4; 32'hFFFF_FFFC + 4 wraps to 0.
    - If next[1:0] != 0: misaligned_fault<=1, instr_valid<=0, go to S_FAULT, pc unchanged.
    - Else: pc<=next, instr_valid<=0, go to S_REQ.
  - branch, zero and branch_offset are don't-care when no handoff occurs.
- S_FAULT: terminal until reset. No requests issued, instr_valid=0, misaligned_fault=1.
- Protocol errors: imem_rsp_valid outside S_WAIT is ignored and the data dropped.
- At most one request outstanding; no speculation or prefetch.
- Reset mid-operation: an outstanding memory response is abandoned. Memory must not return a response for a pre-reset request after reset deasserts (system guarantee).
- Stall: instr_ready low holds S_HOLD indefinitely with all outputs stable.

Decomposition:
- Package riscv_fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {S_REQ, S_WAIT, S_HOLD, S_FAULT}.
  - localparam PC_STEP = 4.
  - localparam DEFAULT_RESET_PC.
- One sub-module: pc_next_sel. Combinational; inputs instr_pc, branch_offset, branch, zero; outputs next_pc and misaligned.
- The FSM, PC register and counter stay in the top module.

Test Plan:
- Reset release, memory ready=1, response 1 cycle after accept with data 32'h0000_0013 -> first imem_addr=0x0; instr_valid after 2 cycles with instr=0x13, instr_pc=0x0.
- Sequential fetch: three handoffs with branch=0 -> imem_addr 0x0, 0x4, 0x8; retired_count=3.
- Taken branch: instr_pc=0x8, branch=1, zero=1, branch_offset=-4 (0xFFFF_FFFC) -> next imem_addr=0x0; same stimulus with zero=0 -> 0xC.
- Backpressure: imem_req_ready low 5 cycles, then instr_ready low 7 cycles -> imem_addr and instr stable throughout; one request, one handoff.
- Misaligned: instr_pc=0x10, branch=zero=1, branch_offset=1 (target 0x12) -> misaligned_fault=1, imem_req_valid stays 0; reset clears fault and restarts at RESET_PC.
- Wrap and reset-in-flight: instr_pc=0xFFFF_FFFC, no branch -> next imem_addr=0x0. Assert reset while in S_WAIT -> all outputs return to reset values asynchronously; a stray rsp_valid before the next request is ignored.
